// File: rtl/alu_bus_controller.sv
// Sequencer for a tristated 4-bit add/sub unit: routes operands,
// enables the unit onto the internal bus, then captures the result.
module alu_bus_controller #(
    parameter int unsigned SETTLE = 2
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Start,
    input  logic       Sub,
    input  logic [3:0] OpA,
    input  logic [3:0] OpB,
    input  logic [3:0] IB_Alu,
    input  logic       Carry,
    output logic [3:0] A,
    output logic [3:0] B,
    output logic       AddSub,
    output logic       EnableAlu,
    output logic       Busy,
    output logic       Done,
    output logic [3:0] Result,
    output logic       CarryOut,
    output logic       Zero
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_DRIVE,
        S_DONE
    } state_t;

    localparam logic [3:0] LAST = 4'(SETTLE - 1);

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_cnt;
    logic       w_last;
    logic [3:0] r_a;
    logic [3:0] r_b;
    logic       r_addsub;
    logic       r_en;
    logic       r_busy;
    logic       r_done;
    logic [3:0] r_result;
    logic       r_carry;
    logic       r_zero;

    assign w_last = (r_cnt == LAST);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (Start) w_next = S_SETUP;
            S_SETUP: w_next = S_DRIVE;
            S_DRIVE: if (w_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Status outputs are registered decodes of the next state.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            r_a      <= 4'd0;
            r_b      <= 4'd0;
            r_addsub <= 1'b0;
            r_en     <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= 4'd0;
            r_carry  <= 1'b0;
            r_zero   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_en    <= (w_next == S_DRIVE);
            r_busy  <= (w_next != S_IDLE);
            r_done  <= (w_next == S_DONE);
            if (r_state == S_IDLE && Start) begin
                r_a      <= Sub ? OpB : OpA;
                r_b      <= Sub ? OpA : OpB;
                r_addsub <= Sub;
            end
            if (r_state == S_DRIVE) begin
                r_cnt <= w_last ? 4'd0 : r_cnt + 4'd1;
                if (w_last) begin
                    r_result <= IB_Alu;
                    r_carry  <= Carry;
                    r_zero   <= (IB_Alu == 4'd0);
                end
            end else begin
                r_cnt <= 4'd0;
            end
        end
    end

    assign A         = r_a;
    assign B         = r_b;
    assign AddSub    = r_addsub;
    assign EnableAlu = r_en;
    assign Busy      = r_busy;
    assign Done      = r_done;
    assign Result    = r_result;
    assign CarryOut  = r_carry;
    assign Zero      = r_zero;

endmodule

// File: tb/tb_alu_bus_controller.sv
// Directed bench for alu_bus_controller at SETTLE = 2, 1 and 15,
// each instance paired with a behavioural tristated add/sub unit.
module tb_alu_bus_controller;

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic       Start = 1'b0;
    logic       Sub   = 1'b0;
    logic [3:0] OpA   = 4'd0;
    logic [3:0] OpB   = 4'd0;

    logic [3:0] a_m, b_m, ib_m, res_m;
    logic       as_m, en_m, busy_m, done_m, cy_m, co_m, z_m;
    logic [4:0] f_m;
    logic [3:0] a_p, b_p, ib_p, res_p;
    logic       as_p, en_p, busy_p, done_p, cy_p, co_p, z_p;
    logic [4:0] f_p;
    logic [3:0] a_q, b_q, ib_q, res_q;
    logic       as_q, en_q, busy_q, done_q, cy_q, co_q, z_q;
    logic [4:0] f_q;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 Clock = ~Clock;

    function automatic logic [4:0] alu(input logic [3:0] a, input logic [3:0] b,
                                       input logic s);
        return {1'b0, b} + {1'b0, (s ? ~a : a)} + {4'd0, s};
    endfunction

    // Bus reads a junk value when the unit is not enabled.
    assign f_m  = alu(a_m, b_m, as_m);
    assign ib_m = en_m ? f_m[3:0] : 4'hA;
    assign cy_m = f_m[4];
    assign f_p  = alu(a_p, b_p, as_p);
    assign ib_p = en_p ? f_p[3:0] : 4'hA;
    assign cy_p = f_p[4];
    assign f_q  = alu(a_q, b_q, as_q);
    assign ib_q = en_q ? f_q[3:0] : 4'hA;
    assign cy_q = f_q[4];

    alu_bus_controller #(.SETTLE(2)) u_m (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Sub(Sub),
        .OpA(OpA), .OpB(OpB), .IB_Alu(ib_m), .Carry(cy_m),
        .A(a_m), .B(b_m), .AddSub(as_m), .EnableAlu(en_m),
        .Busy(busy_m), .Done(done_m), .Result(res_m),
        .CarryOut(co_m), .Zero(z_m)
    );

    alu_bus_controller #(.SETTLE(1)) u_p (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Sub(Sub),
        .OpA(OpA), .OpB(OpB), .IB_Alu(ib_p), .Carry(cy_p),
        .A(a_p), .B(b_p), .AddSub(as_p), .EnableAlu(en_p),
        .Busy(busy_p), .Done(done_p), .Result(res_p),
        .CarryOut(co_p), .Zero(z_p)
    );

    alu_bus_controller #(.SETTLE(15)) u_q (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Sub(Sub),
        .OpA(OpA), .OpB(OpB), .IB_Alu(ib_q), .Carry(cy_q),
        .A(a_q), .B(b_q), .AddSub(as_q), .EnableAlu(en_q),
        .Busy(busy_q), .Done(done_q), .Result(res_q),
        .CarryOut(co_q), .Zero(z_q)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run(input string tag, input logic s,
                       input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] ea, input logic [3:0] eb,
                       input logic eas, input logic [3:0] eres,
                       input logic ecy, input logic ez, input bit intf);
        int nen;
        int ndone;
        int dedge;
        nen   = 0;
        ndone = 0;
        dedge = 0;
        @(negedge Clock);
        Start = 1'b1;
        Sub   = s;
        OpA   = a;
        OpB   = b;
        @(posedge Clock);
        #1;
        Start = 1'b0;
        Sub   = ~s;
        OpA   = ~a;
        OpB   = ~b;
        chk({tag, ".A"}, a_m, ea);
        chk({tag, ".B"}, b_m, eb);
        chk({tag, ".AddSub"}, as_m, eas);
        chk({tag, ".busy_setup"}, busy_m, 1);
        chk({tag, ".en_setup"}, en_m, 0);
        for (int n = 1; n <= 8; n++) begin
            if (intf && n == 2) begin
                Start = 1'b1;
                Sub   = 1'b1;
                OpA   = 4'd1;
                OpB   = 4'd1;
            end
            if (n == 5) Start = 1'b0;
            @(posedge Clock);
            #1;
            if (en_m) nen++;
            if (done_m) begin
                ndone++;
                dedge = n;
            end
        end
        Start = 1'b0;
        chk({tag, ".en_cycles"}, nen, 2);
        chk({tag, ".done_pulses"}, ndone, 1);
        chk({tag, ".done_edge"}, dedge, 3);
        chk({tag, ".Result"}, res_m, eres);
        chk({tag, ".CarryOut"}, co_m, ecy);
        chk({tag, ".Zero"}, z_m, ez);
        chk({tag, ".busy_end"}, busy_m, 0);
        chk({tag, ".A_held"}, a_m, ea);
    endtask

    initial begin
        int nd;
        int en1, en15, d1, d15;
        #2;
        Reset = 1'b1;
        #1;
        chk("rst.A", a_m, 0);
        chk("rst.B", b_m, 0);
        chk("rst.Result", res_m, 0);
        chk("rst.Busy", busy_m, 0);
        chk("rst.En", en_m, 0);
        chk("rst.Done", done_m, 0);
        chk("rst.Zero", z_m, 0);
        @(negedge Clock);
        @(negedge Clock);
        Reset = 1'b0;

        run("add53", 1'b0, 4'd5, 4'd3, 4'd5, 4'd3, 1'b0, 4'h8, 1'b0, 1'b0, 1'b0);
        run("add97", 1'b0, 4'd9, 4'd7, 4'd9, 4'd7, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
        run("sub35", 1'b1, 4'd3, 4'd5, 4'd5, 4'd3, 1'b1, 4'hE, 1'b0, 1'b0, 1'b0);
        run("sub77", 1'b1, 4'd7, 4'd7, 4'd7, 4'd7, 1'b1, 4'h0, 1'b1, 1'b1, 1'b0);
        run("ignore", 1'b0, 4'd5, 4'd3, 4'd5, 4'd3, 1'b0, 4'h8, 1'b0, 1'b0, 1'b1);

        // Reset between edges while the bus is being driven.
        @(negedge Clock);
        Start = 1'b1;
        Sub   = 1'b0;
        OpA   = 4'd4;
        OpB   = 4'd4;
        @(posedge Clock);
        #1;
        Start = 1'b0;
        @(posedge Clock);
        #1;
        chk("mid.en_drive", en_m, 1);
        #2;
        Reset = 1'b1;
        #1;
        chk("mid.En", en_m, 0);
        chk("mid.Busy", busy_m, 0);
        chk("mid.Done", done_m, 0);
        chk("mid.A", a_m, 0);
        chk("mid.B", b_m, 0);
        chk("mid.Result", res_m, 0);
        chk("mid.CarryOut", co_m, 0);
        chk("mid.Zero", z_m, 0);
        @(negedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
        nd = 0;
        for (int n = 0; n < 6; n++) begin
            @(posedge Clock);
            #1;
            if (done_m) nd++;
        end
        chk("mid.no_done", nd, 0);

        run("after", 1'b1, 4'd3, 4'd5, 4'd5, 4'd3, 1'b1, 4'hE, 1'b0, 1'b0, 1'b0);

        @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        en1  = 0;
        en15 = 0;
        d1   = 0;
        d15  = 0;
        Start = 1'b1;
        Sub   = 1'b0;
        OpA   = 4'd5;
        OpB   = 4'd3;
        @(posedge Clock);
        #1;
        Start = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge Clock);
            #1;
            if (en_p) en1++;
            if (en_q) en15++;
            if (done_p) d1 = n;
            if (done_q) d15 = n;
        end
        chk("s1.en_cycles", en1, 1);
        chk("s1.done_edge", d1, 2);
        chk("s1.Result", res_p, 8);
        chk("s15.en_cycles", en15, 15);
        chk("s15.done_edge", d15, 16);
        chk("s15.Result", res_q, 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_bus_controller.md
ALU_BUS_CONTROLLER -- requirements
Module: alu_bus_controller

Interface
REQ-001 SHALL provide parameter: SETTLE, 2, number of cycles EnableAlu is held high before the internal bus is sampled (legal 1..15).
REQ-002 SHALL provide port: Clock  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL provide port: Reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL provide port: Start  input  1  request one operation; sampled only in IDLE.
REQ-005 SHALL provide port: Sub  input  1  0 = OpA+OpB, 1 = OpA-OpB; sampled with Start.
REQ-006 SHALL provide port: OpA  input  4  first operand; sampled with Start.
REQ-007 SHALL provide port: OpB  input  4  second operand; sampled with Start.
REQ-008 SHALL provide port: IB_Alu  input  4  internal bus driven by the arithmetic unit when EnableAlu=1.
REQ-009 SHALL provide port: Carry  input  1  carry-out of the arithmetic unit.
REQ-010 SHALL provide port: A  output  4  arithmetic unit A operand.
REQ-011 SHALL provide port: B  output  4  arithmetic unit B operand.
REQ-012 SHALL provide port: AddSub  output  1  arithmetic unit mode (1 = computes B + ~A + 1).
REQ-013 SHALL provide port: EnableAlu  output  1  tristate enable of the arithmetic unit onto IB_Alu.
REQ-014 SHALL provide port: Busy  output  1  high in every state except IDLE.
REQ-015 SHALL provide port: Done  output  1  one-cycle pulse, result registers valid.
REQ-016 SHALL provide port: Result  output  4  captured bus value.
REQ-017 SHALL provide port: CarryOut  output  1  captured Carry.
REQ-018 SHALL provide port: Zero  output  1  high when captured Result == 0.

Function
REQ-019 SHALL implement states IDLE, SETUP, DRIVE, DONE; all outputs registered.
REQ-020 IDLE: Start=1 at an edge SHALL latch Sub/OpA/OpB and go to SETUP; Start=0 stays IDLE.
REQ-021 Start while Busy=1 or in DONE SHALL be ignored, with no queuing.
REQ-022 Operand routing, Sub=0: A=OpA, B=OpB, AddSub=0.
REQ-023 Operand routing, Sub=1: A=OpB, B=OpA, AddSub=1, so the bus carries OpA-OpB mod 16 and CarryOut=1 means no borrow.
REQ-024 A, B and AddSub SHALL be valid from SETUP entry and held unchanged until the next accepted Start.
REQ-025 SETUP SHALL last exactly 1 cycle with EnableAlu=0, then go to DRIVE.
REQ-026 DRIVE SHALL hold EnableAlu=1 for exactly SETTLE cycles, counted by an internal 4-bit counter.
REQ-027 At the edge ending the last DRIVE cycle, the block SHALL register IB_Alu into Result, Carry into CarryOut and (IB_Alu==0) into Zero, deassert EnableAlu, and go to DONE.
REQ-028 DONE SHALL last 1 cycle with Done=1 and Busy=1, then go to IDLE.
REQ-029 Latency: if Start is sampled at edge k, Done SHALL be high in the cycle following edge k+1+SETTLE.
REQ-030 Result, CarryOut and Zero SHALL hold their values until the next capture.
REQ-031 EnableAlu SHALL never be high outside DRIVE.

Reset
REQ-032 Reset=1 SHALL immediately, without a clock edge, force IDLE, EnableAlu=0, Busy=0, Done=0, A=0, B=0, AddSub=0, Result=0, CarryOut=0, Zero=0 and counter=0.
REQ-033 Reset asserted mid-operation SHALL abandon the operation with no Done pulse; the first Start after release SHALL be handled normally.

Verification
REQ-034 SETTLE=2, Start with Sub=0, OpA=5, OpB=3 -> A=5, B=3, AddSub=0; EnableAlu high exactly 2 cycles; Done 3 edges after the start edge; Result=8, CarryOut=0, Zero=0.
REQ-035 Sub=0, OpA=9, OpB=7 -> Result=0, CarryOut=1, Zero=1.
REQ-036 Sub=1, OpA=3, OpB=5 -> A=5, B=3, AddSub=1; Result=0xE, CarryOut=0, Zero=0; Sub=1, OpA=7, OpB=7 -> Result=0, CarryOut=1, Zero=1.
REQ-037 Start pulsed again during DRIVE with different operands -> ignored; exactly one Done pulse; Result from the first operands.
REQ-038 Reset asserted mid-DRIVE between clock edges -> EnableAlu and Busy drop to 0 before the next edge; no Done pulse; all outputs 0.
REQ-039 SETTLE=1 and SETTLE=15 -> EnableAlu high exactly 1 and 15 cycles respectively; Done at edges k+2 and k+16.
